// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receive FSM and its testbench.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive byte FIFO.
// Push while full only lands when a pop frees the head slot.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_push,
  input  logic [7:0]                    i_wdata,
  input  logic                          i_pop,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign o_valid = (count != '0);
  assign o_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign o_level = count;
  assign o_data  = o_valid ? mem[rptr] : 8'h00;
  assign pop_ok  = i_pop && o_valid;
  assign push_ok = i_push && (!o_full || pop_ok);

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: pin synchronizer, deframing FSM,
// sticky error flags and a receive FIFO on a valid/ready stream.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_uart_rx,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_frame_err,
  output logic                        o_overrun,
  input  logic                        i_clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic                      rx_m;
  logic                      rx_s;
  uart_rx_state_t            state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bidx;
  logic [UART_DATA_BITS-1:0] sh;
  logic                      stop_tick;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      ferr_set;
  logic                      ovr_set;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_m <= UART_IDLE_LEVEL;
      rx_s <= UART_IDLE_LEVEL;
    end else begin
      rx_m <= i_uart_rx;
      rx_s <= rx_m;
    end
  end

  assign stop_tick = (state == STOP) && (cnt == LAST);
  assign push      = stop_tick && (rx_s == UART_IDLE_LEVEL);
  assign ferr_set  = stop_tick && (rx_s != UART_IDLE_LEVEL);
  assign pop       = o_valid && i_ready;
  assign ovr_set   = push && full && !pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      sh    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_s != UART_IDLE_LEVEL) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            bidx  <= '0;
            state <= (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            sh   <= {rx_s, sh[UART_DATA_BITS-1:1]};
            bidx <= bidx + 1'b1;
            if (bidx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= (rx_s == UART_IDLE_LEVEL) ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s == UART_IDLE_LEVEL) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (ferr_set)       o_frame_err <= 1'b1;
      else if (i_clr_err) o_frame_err <= 1'b0;
      if (ovr_set)        o_overrun   <= 1'b1;
      else if (i_clr_err) o_overrun   <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_wdata (sh),
    .i_pop   (pop),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_level (o_level),
    .o_full  (full)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// Popped beats are logged with their cycle number and checked against hand-computed values.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic [2:0] level;
  logic       ferr;
  logic       ovr;
  logic       clr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c;
  logic [7:0] q[$];
  int qc[$];

  uart_rx #(
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_uart_rx   (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_level     (level),
    .o_frame_err (ferr),
    .o_overrun   (ovr),
    .i_clr_err   (clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && ready) begin
      q.push_back(data);
      qc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < q.size()) ? 32'(q[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] qt(input int i);
    return (i < qc.size()) ? 32'(qc[i]) : 32'hDEAD;
  endfunction

  // One 160-cycle frame; optional one-cycle ready pulse at offset rdy_at.
  task automatic send(input logic [7:0] b, input logic stopv,
                      input int rdy_at, output int c0);
    c0 = cyc;
    for (int k = 0; k < 160; k++) begin
      if (k < 16)       rx = 1'b0;
      else if (k < 144) rx = b[(k-16)/16];
      else              rx = stopv;
      if (k == rdy_at) ready = 1'b1;
      else if (rdy_at >= 0 && k == rdy_at + 1) ready = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rx = 1'b1; ready = 1'b0; clr = 1'b0; rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_level", level, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovr", ovr, 0);

    // basic receive
    ready = 1'b1;
    repeat (5) tick();
    send(8'h55, 1'b1, -1, c);
    chk("basic_cnt", q.size(), 1);
    chk("basic_data", qd(0), 32'h55);
    chk("basic_time", qt(0), c + 155);
    chk("basic_valid", valid, 0);
    chk("basic_ferr", ferr, 0);
    chk("basic_ovr", ovr, 0);

    // glitch
    q.delete(); qc.delete();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk("glitch_cnt", q.size(), 0);
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));
    chk("glitch_ferr", ferr, 0);
    chk("glitch_ovr", ovr, 0);

    // framing error then break
    send(8'hA3, 1'b0, -1, c);
    repeat (48) tick();
    rx = 1'b1;
    repeat (20) tick();
    chk("ferr_set", ferr, 1);
    chk("ferr_drop", q.size(), 0);
    send(8'h3C, 1'b1, -1, c);
    repeat (4) tick();
    chk("ferr_cnt", q.size(), 1);
    chk("ferr_data", qd(0), 32'h3C);
    pulse_clr();
    chk("ferr_clr", ferr, 0);

    // overrun
    ready = 1'b0;
    q.delete(); qc.delete();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, c);
    repeat (4) tick();
    chk("ovr_level", level, 4);
    chk("ovr_flag", ovr, 1);
    chk("ovr_valid", valid, 1);
    chk("ovr_head", data, 8'h01);
    ready = 1'b1;
    repeat (8) tick();
    chk("ovr_cnt", q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_data", qd(i), 32'(i + 1));
      chk("ovr_time", qt(i), qt(0) + i);
    end
    chk("ovr_empty", level, 0);
    pulse_clr();
    chk("ovr_clr", ovr, 0);

    // reset mid-frame
    ready = 1'b0;
    q.delete(); qc.delete();
    send(8'h11, 1'b1, -1, c);
    chk("mid_pre", level, 1);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h7E >> i);
      repeat (16) tick();
    end
    rx = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("mid_valid", valid, 0);
    chk("mid_data", data, 0);
    chk("mid_level", level, 0);
    chk("mid_ferr", ferr, 0);
    chk("mid_ovr", ovr, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("mid_idle", 32'(dut.state), 32'(IDLE));
    ready = 1'b1;
    send(8'h7E, 1'b1, -1, c);
    repeat (4) tick();
    chk("mid_cnt", q.size(), 1);
    chk("mid_rx", qd(0), 32'h7E);

    // back-to-back, push+pop while full
    ready = 1'b0;
    q.delete(); qc.delete();
    send(8'h00, 1'b1, -1, c);
    send(8'hFF, 1'b1, -1, c);
    send(8'h10, 1'b1, -1, c);
    send(8'h20, 1'b1, -1, c);
    send(8'h81, 1'b1, 154, c);
    chk("b2b_level", level, 4);
    chk("b2b_ovr", ovr, 0);
    chk("b2b_head", data, 8'hFF);
    chk("b2b_pop_t", qt(0), c + 154);
    ready = 1'b1;
    repeat (8) tick();
    chk("b2b_cnt", q.size(), 5);
    chk("b2b_d0", qd(0), 32'h00);
    chk("b2b_d1", qd(1), 32'hFF);
    chk("b2b_d2", qd(2), 32'h10);
    chk("b2b_d3", qd(3), 32'h20);
    chk("b2b_d4", qd(4), 32'h81);
    chk("b2b_ferr", ferr, 0);
    chk("b2b_ovr2", ovr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage for the UART peripheral: it samples the asynchronous `i_uart_rx` pin and deframes 8N1 characters. Received bytes are buffered in a small FIFO and presented on a valid/ready byte stream. The Wishbone register front-end consumes that stream as the UART receive data and status source. The block sits between the board pin and the bus-facing UART register logic, in the same clock domain as the bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `i_clk` cycles per bit time. Must be even and ≥ 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of two and ≥ 2.

Ports:
- `i_clk`  in  1  system clock. One clock; all logic on its rising edge.
- `i_reset`  in  1  reset. Synchronous, active-high.
- `i_uart_rx`  in  1  asynchronous serial input. Idle level is 1.
- `o_data`  out  8  byte at the FIFO head.
- `o_valid`  out  1  FIFO is non-empty.
- `i_ready`  in  1  consumer accepts the head. A pop occurs when `o_valid && i_ready`.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `o_frame_err`  out  1  sticky flag: stop bit sampled as 0.
- `o_overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `i_clr_err`  in  1  single-cycle pulse; clears both sticky flags.

## Operation
- **Input synchronizer:** 2-flop synchronizer on `i_uart_rx`. Both flops reset to 1. The FSM uses only the synchronized value `rx_s`.
- **Bit-time counter:** `cnt`, width $clog2(CLKS_PER_BIT). Zeroed on every state entry.
- **Data handling:** bit index `bidx` (3 bits); shift register `sh`. Data arrives LSB-first: each sample shifts `rx_s` into `sh[7]`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when `rx_s==0`, go to START.
  - START: at `cnt==CLKS_PER_BIT/2-1`, sample. If `rx_s==0`, go to DATA with `bidx=0`. Otherwise go to IDLE (glitch rejected, nothing recorded).
  - DATA: at `cnt==CLKS_PER_BIT-1`, sample into `sh`. If `bidx==7`, go to STOP; otherwise increment `bidx`.
  - STOP: at `cnt==CLKS_PER_BIT-1`, sample.
    - `rx_s==1`: push `sh` to the FIFO, then go to IDLE.
    - `rx_s==0`: set `o_frame_err`, drop the byte, then go to WAIT_HIGH.
  - WAIT_HIGH: when `rx_s==1`, go to IDLE. A line held in break never produces bytes.
- **FIFO:** show-ahead; `o_data` equals the head whenever `o_valid` is high. Read and write pointers wrap at `FIFO_DEPTH`.
- **Push when full:**
  - Byte dropped and `o_overrun` set, unless a pop occurs in the same cycle.
  - Simultaneous pop and push when full: both happen, and `o_level` stays at `FIFO_DEPTH`.
- **Push when empty:** no bypass. `o_valid` rises the cycle after the push.
- **Sticky flags:** `i_clr_err` clears both. A set event in the same cycle as `i_clr_err` wins, so the flag reads 1.
- **Reset values:** `o_valid=0`, `o_data=0`, `o_level=0`, `o_frame_err=0`, `o_overrun=0`. FSM in IDLE, FIFO empty, synchronizer flops at 1.
- **Reset mid-frame:** the partial byte is discarded. The next falling edge after reset starts a fresh frame.

## Timing
- Let T be the cycle in which IDLE observes `rx_s==0`. The pin edge precedes T by 2–3 cycles (synchronizer).
- START entered at T+1. Start sample at T+CLKS_PER_BIT/2.
- Data bit k sampled at T+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT, for k=0..7.
- Stop sample at T+CLKS_PER_BIT/2+9·CLKS_PER_BIT. FIFO write occurs on that edge; `o_valid` and `o_data` update the following cycle.
- IDLE is re-entered the cycle after the stop sample, i.e. mid stop bit. A start bit immediately following the stop bit is therefore caught: back-to-back frames are supported.
- Pop: `o_data`, `o_level` and `o_valid` update the cycle after `o_valid && i_ready`.
- Consumer throughput: one byte per cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `uart_rx_state_t`;
  - the constants `UART_DATA_BITS=8` and `UART_IDLE_LEVEL=1'b1`.
- Sub-module `uart_rx_fifo` contains:
  - the parameterised synchronous FIFO (`FIFO_DEPTH`, width 8);
  - the push/pop/full/empty/level logic.
- The top level holds the synchronizer, the FSM and the sticky flags.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and `FIFO_DEPTH=4`.
- **Basic receive:** 0x55 frame, `i_ready=1` -> exactly one beat 0x55 at stop-sample+1. `o_frame_err=0`, `o_overrun=0`.
- **Glitch rejection:** pin low for 4 cycles, then high -> no beat; FSM back in IDLE; both flags 0.
- **Framing error:** 0xA3 frame with stop bit 0, line then held low 3 bit-times, released, then a 0x3C frame -> `o_frame_err=1`, only 0x3C delivered. `i_clr_err` pulse -> `o_frame_err=0`.
- **Overrun:** `i_ready=0`, bytes 0x01..0x05 sent -> `o_level=4` and `o_overrun=1`. Raising `i_ready` drains 0x01,0x02,0x03,0x04 on consecutive cycles.
- **Reset mid-frame:** `i_reset` asserted during data bit 3 -> all outputs at reset values. The next full 0x7E frame is received as 0x7E.
- **Back-to-back frames:** frames 0x00 then 0xFF with no idle gap, and a 0x81 push coinciding with a pop while the FIFO is full -> all bytes delivered in order, no flag set.
